yutorina_if_stage: RTL and testbench

- Instruction-fetch stage; sits directly upstream of the pipeline control unit.
- Consumes that unit's stall and flush outputs and produces the i_busy input it consumes.
- Owns the PC, the instruction-bus request/ready handshake and the IF/ID pipeline register that feeds decode.

---
 rtl/yutorina_if_stage.sv | 212 +++++++++++++++++++++
 tb/tb_yutorina_if_stage.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/yutorina_if_stage.sv
// Instruction-fetch stage: PC, instruction-bus handshake, stall hold buffer and IF/ID register.
// Optional YUTORINA_IF_PERF_EN adds perf_fetch / perf_wait event counters.
module yutorina_if_stage #(
  parameter int                ADDR_W       = 30,
  parameter int                DATA_W       = 32,
  parameter logic [ADDR_W-1:0] RESET_VECTOR = '0,
  parameter logic [DATA_W-1:0] NOP_INSN     = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  input  logic              flush,
  input  logic [ADDR_W-1:0] new_pc,
  input  logic              br_taken,
  input  logic [ADDR_W-1:0] br_addr,
  output logic              bus_req,
  output logic [ADDR_W-1:0] bus_addr,
  input  logic              bus_rdy,
  input  logic [DATA_W-1:0] bus_rd_data,
  output logic              i_busy,
  output logic [ADDR_W-1:0] if_pc,
  output logic [DATA_W-1:0] if_insn,
  output logic              if_en_
`ifdef YUTORINA_IF_PERF_EN
  ,
  output logic [31:0]       perf_fetch,
  output logic [31:0]       perf_wait
`endif
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    HOLD   = 2'd2,
    DRAIN  = 2'd3
  } state_t;

  state_t              r_state;
  logic [ADDR_W-1:0]   r_pc;
  logic [ADDR_W-1:0]   r_bus_addr;
  logic                r_bus_req;
  logic [ADDR_W-1:0]   r_if_pc;
  logic [DATA_W-1:0]   r_if_insn;
  logic                r_if_en_n;
  logic [ADDR_W-1:0]   r_hold_pc;
  logic [DATA_W-1:0]   r_hold_insn;

  state_t              w_state_next;
  logic [ADDR_W-1:0]   w_pc_next;
  logic [ADDR_W-1:0]   w_bus_addr_next;
  logic                w_bus_req_next;
  logic [ADDR_W-1:0]   w_if_pc_next;
  logic [DATA_W-1:0]   w_if_insn_next;
  logic                w_if_en_n_next;
  logic [ADDR_W-1:0]   w_hold_pc_next;
  logic [DATA_W-1:0]   w_hold_insn_next;
  logic                w_fetch;
  logic                w_redirect;
  logic [ADDR_W-1:0]   w_target;

  assign w_redirect = flush | br_taken;
  assign w_target   = flush ? new_pc : br_addr;

  // Deliberately independent of stall, which is itself derived from i_busy.
  assign i_busy = ((r_state == ACCESS) && !bus_rdy) || (r_state == DRAIN);

  always_comb begin
    w_state_next     = r_state;
    w_pc_next        = r_pc;
    w_bus_addr_next  = r_bus_addr;
    w_bus_req_next   = r_bus_req;
    w_if_pc_next     = r_if_pc;
    w_if_insn_next   = r_if_insn;
    w_if_en_n_next   = r_if_en_n;
    w_hold_pc_next   = r_hold_pc;
    w_hold_insn_next = r_hold_insn;
    w_fetch          = 1'b0;

    if (w_redirect) begin
      w_pc_next      = w_target;
      w_if_en_n_next = 1'b1;
      if (flush) begin
        w_if_insn_next = NOP_INSN;
      end
    end

    case (r_state)
      IDLE: begin
        if (w_redirect) begin
          w_state_next    = ACCESS;
          w_bus_addr_next = w_target;
          w_bus_req_next  = 1'b1;
        end else if (!stall) begin
          w_state_next    = ACCESS;
          w_bus_addr_next = r_pc;
          w_bus_req_next  = 1'b1;
        end
      end

      ACCESS: begin
        if (w_redirect) begin
          if (bus_rdy) begin
            w_bus_addr_next = w_target;
          end else begin
            w_state_next = DRAIN;
          end
        end else if (bus_rdy) begin
          w_pc_next = r_bus_addr + ADDR_W'(1);
          if (stall) begin
            w_state_next     = HOLD;
            w_bus_req_next   = 1'b0;
            w_hold_pc_next   = r_bus_addr;
            w_hold_insn_next = bus_rd_data;
          end else begin
            w_bus_addr_next = r_pc + ADDR_W'(1);
            w_if_pc_next    = r_bus_addr;
            w_if_insn_next  = bus_rd_data;
            w_if_en_n_next  = 1'b0;
            w_fetch         = 1'b1;
          end
        end else if (!stall) begin
          w_if_en_n_next = 1'b1;
        end
      end

      HOLD: begin
        if (w_redirect) begin
          w_state_next    = ACCESS;
          w_bus_addr_next = w_target;
          w_bus_req_next  = 1'b1;
        end else if (!stall) begin
          // pc already points one past the held instruction.
          w_state_next    = ACCESS;
          w_bus_addr_next = r_pc;
          w_bus_req_next  = 1'b1;
          w_if_pc_next    = r_hold_pc;
          w_if_insn_next  = r_hold_insn;
          w_if_en_n_next  = 1'b0;
          w_fetch         = 1'b1;
        end
      end

      DRAIN: begin
        // A redirect arriving with the abandoned beat's ready goes straight to the new target.
        if (bus_rdy) begin
          w_state_next    = ACCESS;
          w_bus_addr_next = w_redirect ? w_target : r_pc;
        end
      end

      default: begin
        w_state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state     <= IDLE;
      r_pc        <= RESET_VECTOR;
      r_bus_addr  <= '0;
      r_bus_req   <= 1'b0;
      r_if_pc     <= '0;
      r_if_insn   <= NOP_INSN;
      r_if_en_n   <= 1'b1;
      r_hold_pc   <= '0;
      r_hold_insn <= '0;
    end else begin
      r_state     <= w_state_next;
      r_pc        <= w_pc_next;
      r_bus_addr  <= w_bus_addr_next;
      r_bus_req   <= w_bus_req_next;
      r_if_pc     <= w_if_pc_next;
      r_if_insn   <= w_if_insn_next;
      r_if_en_n   <= w_if_en_n_next;
      r_hold_pc   <= w_hold_pc_next;
      r_hold_insn <= w_hold_insn_next;
    end
  end

  assign bus_req  = r_bus_req;
  assign bus_addr = r_bus_addr;
  assign if_pc    = r_if_pc;
  assign if_insn  = r_if_insn;
  assign if_en_   = r_if_en_n;

`ifdef YUTORINA_IF_PERF_EN
  logic [31:0] r_perf_fetch;
  logic [31:0] r_perf_wait;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_perf_fetch <= '0;
      r_perf_wait  <= '0;
    end else begin
      if (w_fetch) begin
        r_perf_fetch <= r_perf_fetch + 32'd1;
      end
      if (i_busy) begin
        r_perf_wait <= r_perf_wait + 32'd1;
      end
    end
  end

  assign perf_fetch = r_perf_fetch;
  assign perf_wait  = r_perf_wait;
`else
  logic w_fetch_unused;
  assign w_fetch_unused = w_fetch;
`endif

endmodule

// File: tb/tb_yutorina_if_stage.sv
// Directed bench for yutorina_if_stage: reset, zero-wait, wait states, stall/hold, flush drain, priority, wrap.
module tb_yutorina_if_stage;

  localparam int ADDR_W = 30;
  localparam int DATA_W = 32;
  localparam logic [ADDR_W-1:0] RV  = 30'h100;
  localparam logic [DATA_W-1:0] NOP = 32'h0000_0013;

  logic              clk;
  logic              rst;
  logic              stall;
  logic              flush;
  logic [ADDR_W-1:0] new_pc;
  logic              br_taken;
  logic [ADDR_W-1:0] br_addr;
  logic              bus_req;
  logic [ADDR_W-1:0] bus_addr;
  logic              bus_rdy;
  logic [DATA_W-1:0] bus_rd_data;
  logic              i_busy;
  logic [ADDR_W-1:0] if_pc;
  logic [DATA_W-1:0] if_insn;
  logic              if_en_;
`ifdef YUTORINA_IF_PERF_EN
  logic [31:0]       perf_fetch;
  logic [31:0]       perf_wait;
  logic [31:0]       fetch_base;
`endif

  int n_pass  = 0;
  int n_total = 0;

  yutorina_if_stage #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .RESET_VECTOR(RV), .NOP_INSN(NOP)
  ) dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush), .new_pc(new_pc),
    .br_taken(br_taken), .br_addr(br_addr), .bus_req(bus_req), .bus_addr(bus_addr),
    .bus_rdy(bus_rdy), .bus_rd_data(bus_rd_data), .i_busy(i_busy), .if_pc(if_pc),
    .if_insn(if_insn), .if_en_(if_en_)
`ifdef YUTORINA_IF_PERF_EN
    , .perf_fetch(perf_fetch), .perf_wait(perf_wait)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory returns {2'b11, address} on ready, garbage otherwise.
  assign bus_rd_data = bus_rdy ? {2'b11, bus_addr} : 32'hDEAD_BEEF;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    $display("check %-14s observed %0h expected %0h", tag, obs, exp);
  endtask

  initial begin
    rst = 1'b0; stall = 1'b0; flush = 1'b0; br_taken = 1'b0;
    new_pc = '0; br_addr = '0; bus_rdy = 1'b1;

    tick(); tick();
    check("rst_req", bus_req, 0);
    check("rst_addr", bus_addr, 0);
    check("rst_en", if_en_, 1);
    check("rst_insn", if_insn, NOP);
    check("rst_pc", if_pc, 0);
    check("rst_busy", i_busy, 0);

    // zero-wait fetch from the reset vector
    rst = 1'b1;
    tick();
    check("zw_addr0", bus_addr, 30'h100);
    check("zw_req", bus_req, 1);
    check("zw_en0", if_en_, 1);
    tick();
    check("zw_addr1", bus_addr, 30'h101);
    check("zw_pc0", if_pc, 30'h100);
    check("zw_insn0", if_insn, 32'hC000_0100);
    check("zw_en1", if_en_, 0);
    check("zw_busy", i_busy, 0);
    tick();
    check("zw_addr2", bus_addr, 30'h102);
    check("zw_pc1", if_pc, 30'h101);

    // wait states at 0x10
    br_taken = 1'b1; br_addr = 30'h10;
    tick();
    br_taken = 1'b0;
    check("br_addr", bus_addr, 30'h10);
    check("br_en", if_en_, 1);
    bus_rdy = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("ws_busy", i_busy, 1);
      check("ws_addr", bus_addr, 30'h10);
      tick();
      check("ws_en", if_en_, 1);
    end
    bus_rdy = 1'b1;
    #1;
    check("ws_busy_end", i_busy, 0);
    tick();
    check("ws_insn", if_insn, 32'hC000_0010);
    check("ws_pc", if_pc, 30'h10);
    check("ws_en_end", if_en_, 0);

    // stall on the ready beat of 0x20
    br_taken = 1'b1; br_addr = 30'h20;
    tick();
    br_taken = 1'b0; stall = 1'b1;
    tick();
    check("st_req", bus_req, 0);
    check("st_pc", if_pc, 30'h10);
    check("st_en", if_en_, 1);
    bus_rdy = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("st_busy", i_busy, 0);
      tick();
      check("st_hold_req", bus_req, 0);
      check("st_hold_pc", if_pc, 30'h10);
    end
    stall = 1'b0; bus_rdy = 1'b1;
    tick();
    check("st_rel_pc", if_pc, 30'h20);
    check("st_rel_insn", if_insn, 32'hC000_0020);
    check("st_rel_en", if_en_, 0);
    check("st_next_addr", bus_addr, 30'h21);
    check("st_next_req", bus_req, 1);
    tick();
    check("st_next_pc", if_pc, 30'h21);

    // flush while 0x30 is waiting
    br_taken = 1'b1; br_addr = 30'h30;
    tick();
    br_taken = 1'b0; bus_rdy = 1'b0;
    tick();
    check("fl_wait_addr", bus_addr, 30'h30);
    flush = 1'b1; new_pc = 30'h8;
    tick();
    flush = 1'b0;
    #1;
    check("fl_dr_addr", bus_addr, 30'h30);
    check("fl_dr_req", bus_req, 1);
    check("fl_dr_insn", if_insn, NOP);
    check("fl_dr_en", if_en_, 1);
    check("fl_dr_busy", i_busy, 1);
    tick();
    check("fl_dr_addr2", bus_addr, 30'h30);
    bus_rdy = 1'b1;
    #1;
    check("fl_dr_busy2", i_busy, 1);
    tick();
    check("fl_new_addr", bus_addr, 30'h8);
    check("fl_discard_en", if_en_, 1);
    check("fl_discard_ins", if_insn, NOP);
    tick();
    check("fl_fetch_pc", if_pc, 30'h8);
    check("fl_fetch_insn", if_insn, 32'hC000_0008);
    check("fl_fetch_en", if_en_, 0);

    // flush wins over a same-cycle branch
    br_taken = 1'b1; br_addr = 30'h40; flush = 1'b1; new_pc = 30'h8;
    tick();
    br_taken = 1'b0; flush = 1'b0;
    check("pr_addr", bus_addr, 30'h8);
    check("pr_insn", if_insn, NOP);
    check("pr_en", if_en_, 1);
    tick();
    check("pr_fetch_pc", if_pc, 30'h8);

    // address wrap
    br_taken = 1'b1; br_addr = 30'h3FFF_FFFF;
    tick();
    br_taken = 1'b0;
    check("wr_addr_top", bus_addr, 30'h3FFF_FFFF);
`ifdef YUTORINA_IF_PERF_EN
    fetch_base = perf_fetch;
`endif
    tick();
    check("wr_pc_top", if_pc, 30'h3FFF_FFFF);
    check("wr_insn_top", if_insn, 32'hFFFF_FFFF);
    check("wr_addr_zero", bus_addr, 30'h0);
    tick();
    check("wr_pc_zero", if_pc, 30'h0);
    check("wr_insn_zero", if_insn, 32'hC000_0000);
    check("wr_addr_one", bus_addr, 30'h1);
`ifdef YUTORINA_IF_PERF_EN
    check("pf_fetch_wrap", perf_fetch - fetch_base, 2);
    check("pf_wait", perf_wait, 7);
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
